// File: rtl/ldpc_llr_frame_buffer_pkg.sv
// Shared types and constants for the LDPC LLR frame buffer.
// Symmetric LLR clip bounds and the frame FSM encoding live here.
package ldpc_llr_frame_buffer_pkg;

  localparam int N_DEF     = 198;
  localparam int LLR_W_DEF = 8;

  typedef enum logic [1:0] {
    S_LOAD,
    S_HANDOFF,
    S_DECODE,
    S_UNLOAD
  } state_e;

  function automatic int llr_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Symmetric range: the most negative code is never produced.
  function automatic int llr_min(input int w);
    return -((1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/ldpc_llr_frame_buffer_sat.sv
// One lane of input conversion: arithmetic shift then symmetric clip.
// Purely combinational; sat_o flags a clipped result.
module llr_sat_shift
  import ldpc_llr_frame_buffer_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int LLR_W = LLR_W_DEF,
  parameter int SHIFT = 4
) (
  input  logic [IN_W-1:0]  llr_i,
  output logic [LLR_W-1:0] llr_o,
  output logic             sat_o
);

  localparam logic signed [IN_W-1:0] MAXV = IN_W'(llr_max(LLR_W));
  localparam logic signed [IN_W-1:0] MINV = IN_W'(llr_min(LLR_W));

  logic signed [IN_W-1:0] t;

  always_comb begin
    t     = $signed(llr_i) >>> SHIFT;
    llr_o = t[LLR_W-1:0];
    sat_o = 1'b0;
    if (t > MAXV) begin
      llr_o = MAXV[LLR_W-1:0];
      sat_o = 1'b1;
    end else if (t < MINV) begin
      llr_o = MINV[LLR_W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_llr_frame_buffer.sv
// LLR frame assembly in front of the LDPC decoder and hard-decision
// streaming behind it: LOAD -> HANDOFF -> DECODE -> UNLOAD.
module ldpc_llr_frame_buffer
  import ldpc_llr_frame_buffer_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IN_W  = 12,
  parameter int LLR_W = LLR_W_DEF,
  parameter int SHIFT = 4,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_llr,
  input  logic                  in_last,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic [N*LLR_W-1:0]    llr_frame,
  input  logic                  dec_done,
  input  logic [N-1:0]          dec_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_bits,
  output logic                  out_last,
  output logic [15:0]           sat_count,
  output logic                  frame_err
);

  localparam int IDX_W = $clog2(N + 2 * LANES + 1);
  localparam int PAD   = 1 << IDX_W;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t N_I = idx_t'(N);
  localparam idx_t L_I = idx_t'(LANES);

  // Bits [base +: LANES] of a frame, positions past N read as 0.
  function automatic logic [LANES-1:0] pick(
    input logic [N-1:0] src,
    input idx_t         base
  );
    logic [PAD-1:0] p;
    p        = '0;
    p[N-1:0] = src;
    return p[base +: LANES];
  endfunction

  state_e               state_q, state_d;
  idx_t                 idx_q, idx_d;
  idx_t                 base_q, base_d;
  logic [N*LLR_W-1:0]   frame_q, frame_d;
  logic [N-1:0]         bits_q, bits_d;
  logic [15:0]          sat_q, sat_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 fvalid_q, fvalid_d;
  logic                 ovalid_q, ovalid_d;
  logic [LANES-1:0]     obits_q, obits_d;
  logic                 olast_q, olast_d;

  logic [LLR_W-1:0]     conv [LANES];
  logic [LANES-1:0]     sat;
  logic [LANES-1:0]     sat_hit;
  logic [16:0]          sat_sum;
  idx_t                 idx_end;
  logic                 fire_in;
  logic                 full;
  logic                 close;
  logic                 fire_out;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    llr_sat_shift #(
      .IN_W  (IN_W),
      .LLR_W (LLR_W),
      .SHIFT (SHIFT)
    ) u_sat (
      .llr_i (in_llr[k*IN_W +: IN_W]),
      .llr_o (conv[k]),
      .sat_o (sat[k])
    );
  end

  assign fire_in  = in_valid & in_ready_q & (state_q == S_LOAD);
  assign idx_end  = idx_q + L_I;
  assign full     = idx_end >= N_I;
  assign close    = fire_in & (full | in_last);
  assign fire_out = ovalid_q & out_ready;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sat_hit[k] = sat[k] & ((idx_q + idx_t'(k)) < N_I);
    end
    sat_sum = {1'b0, sat_q} + 17'($countones(sat_hit));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOAD;
      idx_q      <= '0;
      base_q     <= '0;
      frame_q    <= '0;
      bits_q     <= '0;
      sat_q      <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
      fvalid_q   <= 1'b0;
      ovalid_q   <= 1'b0;
      obits_q    <= '0;
      olast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      frame_q    <= frame_d;
      bits_q     <= bits_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      fvalid_q   <= fvalid_d;
      ovalid_q   <= ovalid_d;
      obits_q    <= obits_d;
      olast_q    <= olast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:    if (close) state_d = S_HANDOFF;
      S_HANDOFF: if (frame_ack) state_d = S_DECODE;
      S_DECODE:  if (dec_done) state_d = S_UNLOAD;
      S_UNLOAD:  if (fire_out && olast_q) state_d = S_LOAD;
      default:   state_d = S_LOAD;
    endcase
  end

  always_comb begin
    idx_d    = idx_q;
    base_d   = base_q;
    frame_d  = frame_q;
    bits_d   = bits_q;
    sat_d    = sat_q;
    err_d    = err_q;
    ovalid_d = ovalid_q;
    obits_d  = obits_q;
    olast_d  = olast_q;

    if (fire_in) begin
      // An early in_last zero-fills everything past this beat.
      for (int i = 0; i < N; i++) begin
        if (in_last && idx_t'(i) >= idx_end)
          frame_d[i*LLR_W +: LLR_W] = '0;
        for (int k = 0; k < LANES; k++) begin
          if (idx_q + idx_t'(k) == idx_t'(i))
            frame_d[i*LLR_W +: LLR_W] = conv[k];
        end
      end
      idx_d = idx_end;
      sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      err_d = err_q | (full ^ in_last);
    end

    if (state_q == S_DECODE && dec_done) begin
      bits_d   = dec_bits;
      base_d   = '0;
      ovalid_d = 1'b1;
      obits_d  = pick(dec_bits, '0);
      olast_d  = (L_I >= N_I);
    end

    if (state_q == S_UNLOAD && fire_out) begin
      if (olast_q) begin
        ovalid_d = 1'b0;
        obits_d  = '0;
        olast_d  = 1'b0;
        base_d   = '0;
        idx_d    = '0;
        sat_d    = '0;
      end else begin
        base_d  = base_q + L_I;
        obits_d = pick(bits_q, base_d);
        olast_d = (base_d + L_I) >= N_I;
      end
    end

    in_ready_d = (state_d == S_LOAD);
    fvalid_d   = (state_d == S_HANDOFF);
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = fvalid_q;
  assign llr_frame   = frame_q;
  assign out_valid   = ovalid_q;
  assign out_bits    = obits_q;
  assign out_last    = olast_q;
  assign sat_count   = sat_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_ldpc_llr_frame_buffer.sv
// Scoreboard bench for ldpc_llr_frame_buffer: frames and output beats
// are queued by the driver and checked by an independent monitor.
module tb_ldpc_llr_frame_buffer;

  localparam int N     = 198;
  localparam int IN_W  = 12;
  localparam int LLR_W = 8;
  localparam int SHIFT = 4;
  localparam int LANES = 4;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_llr;
  logic                  in_last;
  logic                  frame_valid;
  logic                  frame_ack;
  logic [N*LLR_W-1:0]    llr_frame;
  logic                  dec_done;
  logic [N-1:0]          dec_bits;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_bits;
  logic                  out_last;
  logic [15:0]           sat_count;
  logic                  frame_err;

  ldpc_llr_frame_buffer #(
    .N(N), .IN_W(IN_W), .LLR_W(LLR_W), .SHIFT(SHIFT), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_llr(in_llr), .in_last(in_last),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .llr_frame(llr_frame),
    .dec_done(dec_done), .dec_bits(dec_bits),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_last(out_last),
    .sat_count(sat_count), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*LLR_W-1:0] llr;
    logic [15:0]        sat;
    logic               err;
  } frame_t;

  typedef struct {
    logic [LANES-1:0] bits;
    logic             last;
  } beat_t;

  frame_t fq[$];
  beat_t  bq[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic frame_t mkframe(input logic [7:0] l0, input logic [7:0] l1,
                                     input logic [7:0] l2, input logic [7:0] l3,
                                     input int filled, input logic [15:0] s,
                                     input logic e);
    frame_t f;
    logic [7:0] v [4];
    v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
    f.llr = '0;
    for (int i = 0; i < filled; i++) f.llr[i*LLR_W +: LLR_W] = v[i % 4];
    f.sat = s;
    f.err = e;
    return f;
  endfunction

  task automatic push_beats(input logic [N-1:0] b);
    beat_t e;
    for (int base = 0; base < N; base += LANES) begin
      for (int k = 0; k < LANES; k++)
        e.bits[k] = (base + k < N) ? b[base + k] : 1'b0;
      e.last = (base + LANES >= N);
      bq.push_back(e);
    end
  endtask

  // Monitor: frames on frame_valid rise, beats on handshake or stall.
  initial begin
    frame_t fe;
    beat_t  be;
    int     bad;
    logic   fv_seen;
    fv_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        fv_seen = 1'b0;
        continue;
      end
      if (frame_valid && !fv_seen) begin
        fv_seen = 1'b1;
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected got 1 exp 0");
        end else begin
          fe  = fq.pop_front();
          bad = -1;
          for (int i = 0; i < N; i++)
            if (bad < 0 && llr_frame[i*LLR_W +: LLR_W] !== fe.llr[i*LLR_W +: LLR_W])
              bad = i;
          checks++;
          if (bad >= 0) begin
            errors++;
            $display("FAIL llr_frame entry %0d got %h exp %h", bad,
                     llr_frame[bad*LLR_W +: LLR_W], fe.llr[bad*LLR_W +: LLR_W]);
          end
          chk("sat_count", 32'(sat_count), 32'(fe.sat));
          chk("frame_err", 32'(frame_err), 32'(fe.err));
        end
      end
      if (!frame_valid) fv_seen = 1'b0;
      if (out_valid) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected got %h exp none", out_bits);
        end else if (out_ready) begin
          be = bq.pop_front();
          chk("out_bits", 32'(out_bits), 32'(be.bits));
          chk("out_last", 32'(out_last), 32'(be.last));
        end else begin
          chk("hold_bits", 32'(out_bits), 32'(bq[0].bits));
          chk("hold_last", 32'(out_last), 32'(bq[0].last));
        end
      end
    end
  end

  task automatic beat(input logic [LANES*IN_W-1:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_llr   = d;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got 0 exp 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input logic [LANES*IN_W-1:0] d, input int nb,
                      input int last_at);
    for (int b = 1; b <= nb; b++) beat(d, b == last_at);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("fv_drop", 32'(frame_valid), 32'd0);
  endtask

  task automatic decode(input logic [N-1:0] b);
    push_beats(b);
    dec_bits = b;
    dec_done = 1'b1;
    @(posedge clk); #1;
    dec_done = 1'b0;
    chk("ov_rise", 32'(out_valid), 32'd1);
  endtask

  task automatic unload(input bit stall);
    int n;
    n = 0;
    out_ready = stall ? 1'b0 : 1'b1;
    while ((bq.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
      out_ready = stall ? (n % 3 == 0) : 1'b1;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL unload_timeout got %0d exp 0", bq.size());
    end
    out_ready = 1'b0;
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("sat_cleared", 32'(sat_count), 32'd0);
  endtask

  logic [N-1:0] bits;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_llr    = '0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
    dec_done  = 1'b0;
    dec_bits  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fvalid", 32'(frame_valid), 32'd0);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_olast", 32'(out_last), 32'd0);
    chk("rst_obits", 32'(out_bits), 32'd0);
    chk("rst_frame", 32'(llr_frame == '0), 32'd1);
    chk("rst_sat", 32'(sat_count), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Partial frame then asynchronous reset.
    send({4{12'h800}}, 10, 0);
    chk("pre_rst_sat", 32'(sat_count), 32'd40);
    rst = 1'b0;
    #2;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_frame", 32'(llr_frame == '0), 32'd1);
    chk("mid_rst_sat", 32'(sat_count), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain frame of 0x010 -> 0x01; last beat drops lanes 2,3.
    fq.push_back(mkframe(8'h01, 8'h01, 8'h01, 8'h01, N, 16'd0, 1'b0));
    send({4{12'h010}}, 49, 0);
    chk("fv_before_close", 32'(frame_valid), 32'd0);
    beat({4{12'h010}}, 1'b1);
    chk("fv_after_close", 32'(frame_valid), 32'd1);
    chk("ready_handoff", 32'(in_ready), 32'd0);
    dec_done = 1'b1;
    @(posedge clk); #1;
    dec_done = 1'b0;
    chk("done_ignored_ov", 32'(out_valid), 32'd0);
    chk("done_ignored_fv", 32'(frame_valid), 32'd1);
    ack();
    for (int i = 0; i < N; i++) bits[i] = (i % 2 == 0);
    decode(bits);
    unload(1'b0);

    // Clip/shift corner values; only 0x800 lanes clip.
    fq.push_back(mkframe(8'h7F, 8'h81, 8'hFF, 8'h00, N, 16'd50, 1'b0));
    send({12'h008, 12'hFF0, 12'h800, 12'h7FF}, 50, 50);
    ack();
    for (int i = 0; i < N; i++) bits[i] = (i % 3 == 0);
    decode(bits);
    unload(1'b1);

    // Early in_last on beat 20: zero-fill, sticky error.
    fq.push_back(mkframe(8'h02, 8'h02, 8'h02, 8'h02, 80, 16'd0, 1'b1));
    send({4{12'h020}}, 20, 20);
    chk("early_fv", 32'(frame_valid), 32'd1);
    ack();
    decode({N{1'b1}});
    unload(1'b0);
    chk("err_sticky", 32'(frame_err), 32'd1);

    // Missing in_last: frame still closes, error set.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    fq.push_back(mkframe(8'hFF, 8'hFF, 8'hFF, 8'hFF, N, 16'd0, 1'b1));
    send({4{12'hFF0}}, 50, 0);
    chk("nolast_fv", 32'(frame_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("frames_drained", 32'(fq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
